// File: rtl/f_d_pipe_reg.sv
// Fetch-to-decode pipeline register: one-cycle F->D capture with flush > stall > load priority.
// Faulting fetches reach decode as NOP_INSTR; saturating stall/flush debug counters run alongside.
module f_d_pipe_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_PC = 32'h0000_0000,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      f_pc,
   input  logic [31:0]      f_instr,
   input  logic [6:2]       f_exc_code,
   input  logic             f_bd,
   output logic [31:0]      d_pc,
   output logic [31:0]      d_instr,
   output logic [6:2]       d_exc_code,
   output logic             d_bd,
   output logic             d_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [31:0]      r_pc;
   logic [31:0]      r_instr;
   logic [6:2]       r_exc_code;
   logic             r_bd;
   logic             r_valid;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_load;
   logic             w_stall_hit;
   logic [31:0]      w_instr;

   assign w_load      = !flush && !stall;
   assign w_stall_hit = stall && !flush;
   // A fetch from a bad address returns junk; only its PC and code matter to CP0.
   assign w_instr     = (f_exc_code == 5'd0) ? f_instr : NOP_INSTR;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc       <= BUBBLE_PC;
         r_instr    <= NOP_INSTR;
         r_exc_code <= 5'd0;
         r_bd       <= 1'b0;
         r_valid    <= 1'b0;
      end else if (flush) begin
         r_pc       <= BUBBLE_PC;
         r_instr    <= NOP_INSTR;
         r_exc_code <= 5'd0;
         r_bd       <= 1'b0;
         r_valid    <= 1'b0;
      end else if (w_load) begin
         r_pc       <= f_pc;
         r_instr    <= w_instr;
         r_exc_code <= f_exc_code;
         r_bd       <= f_bd;
         r_valid    <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_hit && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (flush && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign d_pc       = r_pc;
   assign d_instr    = r_instr;
   assign d_exc_code = r_exc_code;
   assign d_bd       = r_bd;
   assign d_valid    = r_valid;
   assign stall_cnt  = r_stall_cnt;
   assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_f_d_pipe_reg.sv
// Bench for f_d_pipe_reg: directed steps then random traffic against a rule-level model.
// A second instance with 4-bit counters exercises saturation on the same stimulus.
module tb_f_d_pipe_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [31:0] f_pc;
   logic [31:0] f_instr;
   logic [4:0]  f_exc_code;
   logic        f_bd;

   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic [4:0]  d_exc_code;
   logic        d_bd;
   logic        d_valid;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   logic [31:0] n_pc;
   logic [31:0] n_instr;
   logic [4:0]  n_exc_code;
   logic        n_bd;
   logic        n_valid;
   logic [3:0]  n_stall_cnt;
   logic [3:0]  n_flush_cnt;

   int vectors    = 0;
   int miscompares = 0;

   // Model state: what decode should hold, plus raw event counts.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [4:0]  m_exc;
   logic        m_bd;
   logic        m_valid;
   longint      m_nstall;
   longint      m_nflush;

   always #5 clk = ~clk;

   f_d_pipe_reg u_dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .f_pc(f_pc), .f_instr(f_instr), .f_exc_code(f_exc_code), .f_bd(f_bd),
      .d_pc(d_pc), .d_instr(d_instr), .d_exc_code(d_exc_code), .d_bd(d_bd),
      .d_valid(d_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   f_d_pipe_reg #(.CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .f_pc(f_pc), .f_instr(f_instr), .f_exc_code(f_exc_code), .f_bd(f_bd),
      .d_pc(n_pc), .d_instr(n_instr), .d_exc_code(n_exc_code), .d_bd(n_bd),
      .d_valid(n_valid), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
   );

   function automatic longint sat(input longint n, input int w);
      longint lim;
      lim = (longint'(1) << w) - 1;
      return (n > lim) ? lim : n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("d_pc",       d_pc,                      m_pc);
      check("d_instr",    d_instr,                   m_instr);
      check("d_exc_code", {27'd0, d_exc_code},       {27'd0, m_exc});
      check("d_bd",       {31'd0, d_bd},             {31'd0, m_bd});
      check("d_valid",    {31'd0, d_valid},          {31'd0, m_valid});
      check("stall_cnt",  stall_cnt,                 32'(sat(m_nstall, 32)));
      check("flush_cnt",  flush_cnt,                 32'(sat(m_nflush, 32)));
      check("stall_cnt4", {28'd0, n_stall_cnt},      32'(sat(m_nstall, 4)));
      check("flush_cnt4", {28'd0, n_flush_cnt},      32'(sat(m_nflush, 4)));
      check("d_valid4",   {31'd0, n_valid},          {31'd0, m_valid});
   endtask

   task automatic model_clear();
      m_pc = 32'h0; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
      m_nstall = 0; m_nflush = 0;
   endtask

   // Drive one cycle, let the edge happen, update the model, check 1ns after.
   task automatic cycle(input logic s, input logic fl, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [4:0] exc, input logic bd);
      stall = s; flush = fl; f_pc = pc; f_instr = ins; f_exc_code = exc; f_bd = bd;
      @(posedge clk);
      if (fl) begin
         m_pc = 32'h0; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
         m_nflush++;
      end else if (s) begin
         m_nstall++;
      end else begin
         m_pc = pc; m_exc = exc; m_bd = bd; m_valid = 1'b1;
         m_instr = (exc == 5'd0) ? ins : 32'h0;
      end
      #1;
      check_all();
   endtask

   // Assert reset between edges and confirm outputs clear without a clock.
   task automatic async_reset(input string tag);
      #3 reset = 1'b1;
      model_clear();
      #1;
      check({tag, "_valid"}, {31'd0, d_valid}, 32'd0);
      check_all();
      #1 reset = 1'b0;
   endtask

   initial begin
      logic s, fl, bd;
      logic [4:0] exc;
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      f_pc = 32'h0; f_instr = 32'h0; f_exc_code = 5'd0; f_bd = 1'b0;
      model_clear();
      #3;
      check_all();
      #9 reset = 1'b0;

      cycle(0, 0, 32'h3000, 32'h3C01_1234, 5'd0, 0);
      check("load_pc", d_pc, 32'h3000);
      cycle(0, 0, 32'h3002, 32'hDEAD_BEEF, 5'd4, 1);
      check("mask_instr", d_instr, 32'h0);
      cycle(0, 0, 32'h3004, 32'h2402_0005, 5'd0, 0);
      for (int i = 0; i < 3; i++)
         cycle(1, 0, 32'h3008, 32'h0000_000C, 5'd0, 1);
      check("hold_pc", d_pc, 32'h3004);
      check("stall3", stall_cnt, 32'd3);
      cycle(1, 1, 32'h300C, 32'h1111_1111, 5'd0, 0);
      check("flush_cnt1", flush_cnt, 32'd1);
      check("stall_kept", stall_cnt, 32'd3);

      cycle(0, 0, 32'h3008, 32'h0000_000C, 5'd0, 0);
      async_reset("rst_mid");

      // Faulting instruction held under stall keeps masked word and code.
      cycle(0, 0, 32'h0000_0001, 32'hFFFF_FFFF, 5'd4, 1);
      for (int i = 0; i < 20; i++)
         cycle(1, 0, 32'h4000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 5'd0, 0);
      check("sat4", {28'd0, n_stall_cnt}, 32'd15);
      check("held_exc", {27'd0, d_exc_code}, 32'd4);
      cycle(0, 1, 32'h0, 32'h0, 5'd0, 0);
      check("flush4", {28'd0, n_flush_cnt}, 32'd1);

      for (int i = 0; i < 300; i++) begin
         s   = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         bd  = $urandom_range(0, 1) == 1;
         exc = ($urandom_range(0, 4) == 0) ? 5'd4 : 5'd0;
         cycle(s, fl, $urandom, $urandom, exc, bd);
      end

      cycle(0, 0, 32'h5000, 32'h1234_5678, 5'd0, 1);
      cycle(1, 0, 32'h5004, 32'h0, 5'd0, 0);
      async_reset("rst_stall");
      cycle(1, 0, 32'h5008, 32'h0, 5'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "bench did not complete");
   end

endmodule

// File: doc/f_d_pipe_reg.md
Name: f_d_pipe_reg

Overview:
- Fetch-to-decode pipeline register of the P7 MIPS core.
- Captures from the fetch stage each cycle: fetch PC, fetched instruction, fetch-stage exception code (AdEL on an illegal or misaligned PC), and the branch-delay-slot flag.
- Presents them to decode, and handles stall (hold), flush (exception entry / eret), and exception masking of the instruction word.
- Also keeps two saturating debug counters: stall cycles and flush events.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word that replaces flushed or faulting instructions (sll $0,$0,0).
- BUBBLE_PC, 32'h0000_0000, PC value loaded on reset or flush.
- CNT_W, 32, width of the debug counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- stall  input  1  hazard-unit stall; hold all D-side fields.
- flush  input  1  exception entry or eret redirect; insert bubble.
- f_pc  input  32  PC of the instruction currently in fetch.
- f_instr  input  32  instruction word read at f_pc.
- f_exc_code  input  5 [6:2]  fetch exception code; 0 = none, 4 = AdEL.
- f_bd  input  1  fetch instruction sits in a branch delay slot.
- d_pc  output  32  registered PC for decode; this value becomes EPC on a fault.
- d_instr  output  32  registered instruction, or NOP_INSTR when masked.
- d_exc_code  output  5 [6:2]  registered exception code.
- d_bd  output  1  registered delay-slot flag.
- d_valid  output  1  1 = real instruction (faulting ones included), 0 = bubble.
- stall_cnt  output  CNT_W  number of cycles with stall=1 and flush=0, saturating.
- flush_cnt  output  CNT_W  number of cycles with flush=1, saturating.

Behaviour:
- Reset (asynchronous, any time, including mid-stall): outputs go immediately to the following values.
  - d_pc = BUBBLE_PC, d_instr = NOP_INSTR, d_exc_code = 0, d_bd = 0, d_valid = 0.
  - stall_cnt = 0, flush_cnt = 0.
- Update priority at each rising edge with reset low: flush > stall > load.
- Flush: loads the same values as reset into d_pc, d_instr, d_exc_code, d_bd and d_valid. flush_cnt increments. stall is ignored in that cycle and stall_cnt does not increment.
- Stall (flush=0): all D fields hold their previous values; stall_cnt increments.
- Load (flush=0, stall=0):
  - d_pc = f_pc, d_bd = f_bd, d_exc_code = f_exc_code, d_valid = 1.
  - d_instr = f_instr if f_exc_code == 0, else NOP_INSTR.
  - Masking keeps garbage from an illegal address out of decode, while PC and code still reach CP0.
- Latency: exactly one cycle from F inputs to D outputs. There is no combinational path from any input to any output.
- A faulting fetch is still a real instruction: d_valid = 1 with d_exc_code nonzero. The bubble case is only d_valid = 0.
- Counters:
  - Each counter is CNT_W-bit unsigned, +1 per qualifying cycle.
  - Each saturates at all-ones and never wraps.
  - Only reset clears them; flush does not.
- Holding a faulting instruction under stall keeps the masked NOP_INSTR and the nonzero code stable.
- f_bd is captured unchanged; masking does not alter it.
- X-free: every output is driven from registers after reset.

Test Plan:
- Reset asserted asynchronously mid-cycle while d_valid=1 -> outputs clear before the next edge: d_pc=0, d_instr=0, d_valid=0, both counters 0.
- Load f_pc=0x3000, f_instr=0x3C011234, f_exc_code=0, f_bd=0 with stall=flush=0 -> next cycle d_pc=0x3000, d_instr=0x3C011234, d_exc_code=0, d_valid=1.
- Load f_pc=0x3002, f_instr=0xDEADBEEF, f_exc_code=4, f_bd=1 -> d_instr=0, d_exc_code=4, d_pc=0x3002, d_bd=1, d_valid=1.
- After a load of 0x3004, hold stall=1 for 3 cycles while F inputs change to 0x3008 -> D outputs stay at 0x3004 values; stall_cnt=3.
- Assert stall=1 and flush=1 in the same cycle -> bubble inserted (d_valid=0, d_pc=0); flush_cnt=1 and stall_cnt unchanged.
- Set CNT_W=4 and hold stall for 20 cycles -> stall_cnt=15 and stays 15; a single flush then gives flush_cnt=1.
